led_ring_ctrl: RTL and testbench

Parametrised rotary-encoder-to-LED-ring controller: tracks a position on an N-LED ring from debounced encoder pulses, with step acceleration and four display modes cycled by the push button. It sits between the encoder/button front end and the WS2812B serial driver. It presents a frame (LED mask plus intensity) to the driver through a req/ack handshake, so the driver always serialises a stable frame.

---
 rtl/led_ring_if.sv | 24 ++
 rtl/led_ring_ctrl.sv | 81 ++++++++
 tb/tb_led_ring_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/led_ring_if.sv
// led_ring_if: encoder/button inputs and frame handshake between the ring controller and the serial driver.
interface led_ring_if #(
  parameter int N_LEDS = 12,
  parameter int IDX_W  = $clog2(N_LEDS)
) ();
  logic              rot_up;
  logic              rot_dn;
  logic              push;
  logic [1:0]        intensity_in;
  logic              upd_ack;
  logic [N_LEDS-1:0] led_mask;
  logic [7:0]        intensity_out;
  logic              upd_req;
  logic [IDX_W-1:0]  position;
  logic [1:0]        mode;
  modport master (
    input  rot_up, rot_dn, push, intensity_in, upd_ack,
    output led_mask, intensity_out, upd_req, position, mode
  );
  modport slave (
    output rot_up, rot_dn, push, intensity_in, upd_ack,
    input  led_mask, intensity_out, upd_req, position, mode
  );
endinterface

// File: rtl/led_ring_ctrl.sv
// led_ring_ctrl: accelerated encoder position tracking with four display modes and a req/ack frame handoff.
module led_ring_ctrl #(
  parameter int N_LEDS      = 12,
  parameter int IDX_W       = $clog2(N_LEDS),
  parameter int FAST_WINDOW = 4_000_000,
  parameter int FAST_STEP   = 3
) (
  input logic       clk,
  input logic       res,
  led_ring_if.master bus
);
  localparam int GAP_W = $clog2(FAST_WINDOW + 1);
  localparam int SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0]  N_S    = SUM_W'(N_LEDS);
  localparam logic [SUM_W-1:0]  STEP_F = SUM_W'(FAST_STEP);
  localparam logic [GAP_W-1:0]  GAP_MX = GAP_W'(FAST_WINDOW);
  localparam logic [N_LEDS-1:0] ONE    = N_LEDS'(1);
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic [1:0]        mode_q, mode_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              dir_q, dir_d;
  logic [N_LEDS-1:0] tmask_q, tmask_d, mask_q, mask_d;
  logic [7:0]        tint_q, tint_d, int_q, int_d;
  logic              req_q, req_d;
  logic              up, dn, fast, load;
  logic [SUM_W-1:0]  step, pos_x, sum;
  logic [N_LEDS-1:0] dot, bar;
  always_comb begin
    up      = bus.rot_up & ~bus.rot_dn;
    dn      = bus.rot_dn & ~bus.rot_up;
    fast    = (gap_q < GAP_MX) && (dir_q == up);
    step    = fast ? STEP_F : SUM_W'(1);
    pos_x   = {1'b0, pos_q};
    sum     = pos_x + step;
    pos_d   = up ? IDX_W'(sum >= N_S ? sum - N_S : sum)
            : dn ? IDX_W'(pos_x < step ? pos_x + N_S - step : pos_x - step)
            : pos_q;
    gap_d   = (up | dn) ? '0 : (gap_q == GAP_MX) ? gap_q : gap_q + 1'b1;
    dir_d   = (up | dn) ? up : dir_q;
    mode_d  = mode_q + {1'b0, bus.push};
    dot     = ONE << pos_q;
    bar     = (dot << 1) - ONE;
    tmask_d = (mode_q[0] ? bar : dot) ^ {N_LEDS{mode_q[1]}};
    tint_d  = (bus.intensity_in == 2'd0) ? 8'h01
            : (bus.intensity_in == 2'd1) ? 8'h02
            : (bus.intensity_in == 2'd2) ? 8'h08 : 8'h20;
    // shadow is frozen while a request is outstanding; only the latest target is ever presented
    load    = ~req_q & ((tmask_q != mask_q) | (tint_q != int_q));
    mask_d  = load ? tmask_q : mask_q;
    int_d   = load ? tint_q : int_q;
    req_d   = load | (req_q & ~bus.upd_ack);
  end
  always_ff @(posedge clk) begin
    if (res) begin
      pos_q   <= '0;
      mode_q  <= '0;
      gap_q   <= GAP_MX;
      dir_q   <= 1'b1;
      tmask_q <= ONE;
      tint_q  <= 8'h01;
      mask_q  <= ONE;
      int_q   <= 8'h01;
      req_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
      dir_q   <= dir_d;
      tmask_q <= tmask_d;
      tint_q  <= tint_d;
      mask_q  <= mask_d;
      int_q   <= int_d;
      req_q   <= req_d;
    end
  end
  assign bus.led_mask      = mask_q;
  assign bus.intensity_out = int_q;
  assign bus.upd_req       = req_q;
  assign bus.position      = pos_q;
  assign bus.mode          = mode_q;
endmodule

// File: tb/tb_led_ring_ctrl.sv
// tb_led_ring_ctrl: directed walk through stepping, acceleration, modes, handshake and reset.
module tb_led_ring_ctrl;
  localparam int N = 12, IW = 4, FW = 100, FS = 3;
  logic clk = 1'b0;
  logic res = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  led_ring_if #(.N_LEDS(N), .IDX_W(IW)) bus ();
  led_ring_ctrl #(.N_LEDS(N), .IDX_W(IW), .FAST_WINDOW(FW), .FAST_STEP(FS)) dut (
    .clk(clk), .res(res), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic rot(input logic u, input logic d);
    bus.rot_up = u;
    bus.rot_dn = d;
    tick();
    bus.rot_up = 1'b0;
    bus.rot_dn = 1'b0;
  endtask
  task automatic press();
    bus.push = 1'b1;
    tick();
    bus.push = 1'b0;
  endtask
  initial begin
    logic [11:0] e, m;
    logic [11:0] pm [4];
    int hits, first;
    pm = '{12'h03F, 12'hFDF, 12'hFC0, 12'h020};
    bus.rot_up = 1'b0;
    bus.rot_dn = 1'b0;
    bus.push = 1'b0;
    bus.intensity_in = 2'd0;
    bus.upd_ack = 1'b1;
    tick();
    res = 1'b0;
    chk("rst_mask", bus.led_mask, 12'h001);
    chk("rst_int", bus.intensity_out, 8'h01);
    chk("rst_req", bus.upd_req, 1'b0);
    chk("rst_pos", bus.position, 4'd0);
    chk("rst_mode", bus.mode, 2'd0);
    for (int i = 1; i <= 12; i++) begin
      rot(1'b1, 1'b0);
      chk("walk_pos", bus.position, 64'(i % 12));
      hits = 0;
      first = -1;
      m = '0;
      for (int k = 1; k <= 104; k++) begin
        tick();
        if (bus.upd_req) begin
          hits++;
          if (first < 0) begin
            first = k;
            m = bus.led_mask;
          end
        end
      end
      e = 12'h001 << (i % 12);
      chk("walk_reqs", 64'(hits), 64'd1);
      chk("walk_lat", 64'(first), 64'd2);
      chk("walk_mask", m, e);
    end
    rot(1'b1, 1'b0);
    chk("acc_pos1", bus.position, 4'd1);
    tick(9);
    rot(1'b0, 1'b1);
    chk("acc_dn_slow", bus.position, 4'd0);
    tick(9);
    rot(1'b0, 1'b1);
    chk("acc_dn_fast1", bus.position, 4'd9);
    tick(9);
    rot(1'b0, 1'b1);
    chk("acc_dn_fast2", bus.position, 4'd6);
    tick(104);
    rot(1'b0, 1'b1);
    chk("mode_pos5", bus.position, 4'd5);
    tick(4);
    chk("mode_dot", bus.led_mask, 12'h020);
    for (int i = 0; i < 4; i++) begin
      press();
      chk("mode_val", bus.mode, 64'((i + 1) % 4));
      tick(3);
      chk("mode_mask", bus.led_mask, pm[i]);
    end
    tick(104);
    rot(1'b1, 1'b1);
    chk("both_pos", bus.position, 4'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("both_req", bus.upd_req, 1'b0);
    end
    rot(1'b0, 1'b1);
    chk("both_gap_kept", bus.position, 4'd4);
    tick(3);
    rot(1'b1, 1'b1);
    chk("both_pos2", bus.position, 4'd4);
    tick(2);
    rot(1'b0, 1'b1);
    chk("both_dir_kept", bus.position, 4'd1);
    tick(104);
    rot(1'b0, 1'b1);
    chk("hs_pos0", bus.position, 4'd0);
    tick(5);
    chk("hs_mask0", bus.led_mask, 12'h001);
    bus.upd_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(104);
      rot(1'b1, 1'b0);
      chk("hs_pos", bus.position, 64'(i));
    end
    tick(5);
    chk("hs_frozen", bus.led_mask, 12'h002);
    chk("hs_req_held", bus.upd_req, 1'b1);
    bus.upd_ack = 1'b1;
    tick();
    bus.upd_ack = 1'b0;
    chk("hs_req_drop", bus.upd_req, 1'b0);
    tick();
    chk("hs_req_again", bus.upd_req, 1'b1);
    chk("hs_latest", bus.led_mask, 12'h008);
    for (int i = 0; i < 3; i++) press();
    chk("rs_mode3", bus.mode, 2'd3);
    chk("rs_req1", bus.upd_req, 1'b1);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("rs_mask", bus.led_mask, 12'h001);
    chk("rs_int", bus.intensity_out, 8'h01);
    chk("rs_req", bus.upd_req, 1'b0);
    chk("rs_mode", bus.mode, 2'd0);
    chk("rs_pos", bus.position, 4'd0);
    bus.intensity_in = 2'd3;
    tick();
    chk("int_req_early", bus.upd_req, 1'b0);
    tick();
    chk("int_20", bus.intensity_out, 8'h20);
    chk("int_req", bus.upd_req, 1'b1);
    bus.upd_ack = 1'b1;
    tick(2);
    bus.intensity_in = 2'd1;
    tick(2);
    chk("int_02", bus.intensity_out, 8'h02);
    bus.intensity_in = 2'd2;
    tick(2);
    chk("int_08", bus.intensity_out, 8'h08);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
